// File: rtl/rv32i_decode_stage.sv
// rv32i_decode_stage
//   Registered RV32I decode stage sitting between fetch and register-file read.
//   Each accepted instruction is decoded combinationally and the decoded fields
//   and controls are written into a small FIFO skid buffer. The outputs always
//   show the head entry of that buffer, so downstream back-pressure and flushes
//   never disturb an entry that is already being presented.
//
// Parameters
//   PC_W         width of the PC carried with each instruction
//   BUF_DEPTH    skid-buffer entries (1 or 2)
//   ILLEGAL_TRAP 1: flag bad encodings on illegal; 0: bad encodings become NOPs
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   flush                 synchronous discard of all buffered entries
//   in_valid/in_ready     fetch-side handshake (in_ready is registered)
//   in_instr, in_pc       instruction word and its address
//   out_valid/out_ready   decode-side handshake on the head entry
//   out_pc                PC of the head entry
//   rs1, rs2, rd          register indices, 0 where a field is unused
//   imm                   sign-extended immediate
//   alufunc, alu_bit      ALU / compare function (funct3) and SUB/SRA select
//   funcsel               0 ALU result, 1 branch compare
//   pcsel                 0 PC+4, 1 cond branch, 2 JAL, 3 JALR
//   wdsel                 write-back source: 0 PC+4, 1 ALU, 2 MEM, 3 imm
//   asel, bsel            ALU operand A (rs1/PC) and B (rs2/imm) selects
//   werf                  register-file write enable
//   mem_en, mem_rw        memory access and direction (1 read, 0 write)
//   mem_size              load/store funct3 (size and signedness)
//   illegal               head entry carries an illegal encoding
module rv32i_decode_stage #(
  parameter int PC_W         = 32,
  parameter int BUF_DEPTH    = 2,
  parameter int ILLEGAL_TRAP = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [PC_W-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [PC_W-1:0] out_pc,
  output logic [4:0]      rs1,
  output logic [4:0]      rs2,
  output logic [4:0]      rd,
  output logic [31:0]     imm,
  output logic [2:0]      alufunc,
  output logic            alu_bit,
  output logic            funcsel,
  output logic [1:0]      pcsel,
  output logic [1:0]      wdsel,
  output logic            asel,
  output logic            bsel,
  output logic            werf,
  output logic            mem_en,
  output logic            mem_rw,
  output logic [2:0]      mem_size,
  output logic            illegal
);

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_FENCE  = 7'b0001111;

  typedef struct packed {
    logic [PC_W-1:0] pc;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic [31:0]     imm;
    logic [2:0]      alufunc;
    logic            alu_bit;
    logic            funcsel;
    logic [1:0]      pcsel;
    logic [1:0]      wdsel;
    logic            asel;
    logic            bsel;
    logic            werf;
    logic            mem_en;
    logic            mem_rw;
    logic [2:0]      mem_size;
    logic            illegal;
  } entry_t;

  // Immediate builders: the field is packed into the top of a signed word and
  // arithmetically shifted down, which sign-extends from the instruction MSB.
  function automatic logic [31:0] imm_i(input logic [31:0] i);
    logic signed [31:0] s;
    s = signed'({i[31:20], 20'b0}) >>> 20;
    return s;
  endfunction

  function automatic logic [31:0] imm_s(input logic [31:0] i);
    logic signed [31:0] s;
    s = signed'({i[31:25], i[11:7], 20'b0}) >>> 20;
    return s;
  endfunction

  function automatic logic [31:0] imm_b(input logic [31:0] i);
    logic signed [31:0] s;
    s = signed'({i[31], i[7], i[30:25], i[11:8], 1'b0, 19'b0}) >>> 19;
    return s;
  endfunction

  function automatic logic [31:0] imm_u(input logic [31:0] i);
    return {i[31:12], 12'b0};
  endfunction

  function automatic logic [31:0] imm_j(input logic [31:0] i);
    logic signed [31:0] s;
    s = signed'({i[31], i[19:12], i[20], i[30:21], 1'b0, 11'b0}) >>> 11;
    return s;
  endfunction

  function automatic logic ptr_inc(input logic p);
    return (BUF_DEPTH == 1) ? 1'b0 : ~p;
  endfunction

  logic [6:0] opcode;
  logic [2:0] f3;
  logic [6:0] f7;
  assign opcode = in_instr[6:0];
  assign f3     = in_instr[14:12];
  assign f7     = in_instr[31:25];

  entry_t dec_e;
  logic   bad;

  // ---- decode (combinational on the incoming instruction) ----
  always_comb begin
    dec_e = '0;
    bad   = (in_instr[1:0] != 2'b11);
    case (opcode)
      OPC_LUI: begin
        dec_e.rd    = in_instr[11:7];
        dec_e.imm   = imm_u(in_instr);
        dec_e.wdsel = 2'd3;
        dec_e.werf  = 1'b1;
      end
      OPC_AUIPC: begin
        dec_e.rd    = in_instr[11:7];
        dec_e.imm   = imm_u(in_instr);
        dec_e.asel  = 1'b1;
        dec_e.bsel  = 1'b1;
        dec_e.wdsel = 2'd1;
        dec_e.werf  = 1'b1;
      end
      OPC_JAL: begin
        dec_e.rd    = in_instr[11:7];
        dec_e.imm   = imm_j(in_instr);
        dec_e.pcsel = 2'd2;
        dec_e.werf  = 1'b1;
      end
      OPC_JALR: begin
        bad         = bad | (f3 != 3'b000);
        dec_e.rd    = in_instr[11:7];
        dec_e.rs1   = in_instr[19:15];
        dec_e.imm   = imm_i(in_instr);
        dec_e.pcsel = 2'd3;
        dec_e.werf  = 1'b1;
      end
      OPC_BRANCH: begin
        bad           = bad | (f3 == 3'b010) | (f3 == 3'b011);
        dec_e.rs1     = in_instr[19:15];
        dec_e.rs2     = in_instr[24:20];
        dec_e.imm     = imm_b(in_instr);
        dec_e.alufunc = f3;
        dec_e.funcsel = 1'b1;
        dec_e.pcsel   = 2'd1;
      end
      OPC_LOAD: begin
        bad            = bad | (f3 == 3'b011) | (f3[2:1] == 2'b11);
        dec_e.rd       = in_instr[11:7];
        dec_e.rs1      = in_instr[19:15];
        dec_e.imm      = imm_i(in_instr);
        dec_e.bsel     = 1'b1;
        dec_e.mem_en   = 1'b1;
        dec_e.mem_rw   = 1'b1;
        dec_e.mem_size = f3;
        dec_e.wdsel    = 2'd2;
        dec_e.werf     = 1'b1;
      end
      OPC_STORE: begin
        bad            = bad | (f3 > 3'b010);
        dec_e.rs1      = in_instr[19:15];
        dec_e.rs2      = in_instr[24:20];
        dec_e.imm      = imm_s(in_instr);
        dec_e.bsel     = 1'b1;
        dec_e.mem_en   = 1'b1;
        dec_e.mem_size = f3;
      end
      OPC_OPIMM: begin
        dec_e.rd      = in_instr[11:7];
        dec_e.rs1     = in_instr[19:15];
        dec_e.alufunc = f3;
        dec_e.bsel    = 1'b1;
        dec_e.wdsel   = 2'd1;
        dec_e.werf    = 1'b1;
        // Shift-immediates carry a 5-bit zero-extended shamt; funct7 picks SRL/SRA.
        if (f3 == 3'b001) begin
          dec_e.imm = {27'b0, in_instr[24:20]};
          bad       = bad | (f7 != 7'b0000000);
        end else if (f3 == 3'b101) begin
          dec_e.imm     = {27'b0, in_instr[24:20]};
          dec_e.alu_bit = in_instr[30];
          bad           = bad | ((f7 != 7'b0000000) && (f7 != 7'b0100000));
        end else begin
          dec_e.imm = imm_i(in_instr);
        end
      end
      OPC_OP: begin
        dec_e.rd      = in_instr[11:7];
        dec_e.rs1     = in_instr[19:15];
        dec_e.rs2     = in_instr[24:20];
        dec_e.alufunc = f3;
        dec_e.alu_bit = in_instr[30];
        dec_e.wdsel   = 2'd1;
        dec_e.werf    = 1'b1;
        bad = bad | !((f7 == 7'b0000000) ||
                      ((f7 == 7'b0100000) && ((f3 == 3'b000) || (f3 == 3'b101))));
      end
      OPC_FENCE: begin
        // Treated as a NOP: no register, memory or PC side effects.
      end
      default: begin
        // Includes SYSTEM, which this core does not implement.
        bad = 1'b1;
      end
    endcase
    // A bad encoding becomes an all-zero NOP so it cannot write state or redirect.
    if (bad) begin
      dec_e         = '0;
      dec_e.illegal = (ILLEGAL_TRAP != 0);
    end
    dec_e.pc = in_pc;
  end

  entry_t     buf_q [BUF_DEPTH];
  entry_t     buf_d [BUF_DEPTH];
  logic [1:0] count_q, count_d;
  logic       wr_ptr_q, wr_ptr_d;
  logic       rd_ptr_q, rd_ptr_d;
  logic       in_ready_q, in_ready_d;
  logic       push, pop;

  assign out_valid = (count_q != 2'd0);
  assign in_ready  = in_ready_q;
  assign push      = in_valid & in_ready_q & ~flush;
  assign pop       = out_valid & out_ready & ~flush;

  // ---- skid-buffer control ----
  always_comb begin
    buf_d    = buf_q;
    count_d  = count_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (flush) begin
      count_d  = 2'd0;
      wr_ptr_d = 1'b0;
      rd_ptr_d = 1'b0;
    end else begin
      if (push) begin
        buf_d[wr_ptr_q] = dec_e;
        wr_ptr_d        = ptr_inc(wr_ptr_q);
      end
      if (pop) begin
        rd_ptr_d = ptr_inc(rd_ptr_q);
      end
      case ({push, pop})
        2'b10:   count_d = count_q + 2'd1;
        2'b01:   count_d = count_q - 2'd1;
        default: count_d = count_q;
      endcase
    end
    // in_ready is registered from next occupancy, so a full buffer refuses a
    // push even in a cycle where the head is popped.
    in_ready_d = (count_d < 2'(BUF_DEPTH));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q    <= 2'd0;
      wr_ptr_q   <= 1'b0;
      rd_ptr_q   <= 1'b0;
      in_ready_q <= 1'b1;
      for (int k = 0; k < BUF_DEPTH; k++) begin
        buf_q[k] <= '0;
      end
    end else begin
      count_q    <= count_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      in_ready_q <= in_ready_d;
      for (int k = 0; k < BUF_DEPTH; k++) begin
        buf_q[k] <= buf_d[k];
      end
    end
  end

  // ---- head-entry outputs ----
  entry_t head;
  assign head     = buf_q[rd_ptr_q];
  assign out_pc   = head.pc;
  assign rs1      = head.rs1;
  assign rs2      = head.rs2;
  assign rd       = head.rd;
  assign imm      = head.imm;
  assign alufunc  = head.alufunc;
  assign alu_bit  = head.alu_bit;
  assign funcsel  = head.funcsel;
  assign pcsel    = head.pcsel;
  assign wdsel    = head.wdsel;
  assign asel     = head.asel;
  assign bsel     = head.bsel;
  assign werf     = head.werf;
  assign mem_en   = head.mem_en;
  assign mem_rw   = head.mem_rw;
  assign mem_size = head.mem_size;
  assign illegal  = head.illegal;

endmodule

// File: tb/tb_rv32i_decode_stage.sv
// Scoreboard bench for rv32i_decode_stage: directed instructions with
// hand-decoded expectations are queued on accept and compared by a monitor
// whenever the DUT pops its head entry.
module tb_rv32i_decode_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic [31:0] in_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [4:0]  rs1, rs2, rd;
  logic [31:0] imm;
  logic [2:0]  alufunc;
  logic        alu_bit, funcsel;
  logic [1:0]  pcsel, wdsel;
  logic        asel, bsel, werf, mem_en, mem_rw;
  logic [2:0]  mem_size;
  logic        illegal;

  always #5 clk = ~clk;

  rv32i_decode_stage #(.PC_W(32), .BUF_DEPTH(2), .ILLEGAL_TRAP(1)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
    .rs1(rs1), .rs2(rs2), .rd(rd), .imm(imm), .alufunc(alufunc), .alu_bit(alu_bit),
    .funcsel(funcsel), .pcsel(pcsel), .wdsel(wdsel), .asel(asel), .bsel(bsel),
    .werf(werf), .mem_en(mem_en), .mem_rw(mem_rw), .mem_size(mem_size), .illegal(illegal)
  );

  typedef struct packed {
    logic        loose;   // illegal entry: only the guaranteed-zero fields are compared
    logic [31:0] pc;
    logic [4:0]  rs1, rs2, rd;
    logic [31:0] imm;
    logic [2:0]  alufunc;
    logic        alu_bit, funcsel;
    logic [1:0]  pcsel, wdsel;
    logic        asel, bsel, werf, mem_en, mem_rw;
    logic [2:0]  mem_size;
    logic        illegal;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   errors   = 0;

  function automatic exp_t mk(input logic [4:0] e_rd, e_rs1, e_rs2, input logic [31:0] e_imm,
                              input logic [2:0] e_af, input logic e_ab, e_fs,
                              input logic [1:0] e_pcs, e_wd, input logic e_asl, e_bsl,
                              input logic e_we, e_me, e_mrw, input logic [2:0] e_ms);
    exp_t e;
    e = '0;
    e.rd = e_rd; e.rs1 = e_rs1; e.rs2 = e_rs2; e.imm = e_imm;
    e.alufunc = e_af; e.alu_bit = e_ab; e.funcsel = e_fs; e.pcsel = e_pcs; e.wdsel = e_wd;
    e.asel = e_asl; e.bsel = e_bsl; e.werf = e_we; e.mem_en = e_me; e.mem_rw = e_mrw;
    e.mem_size = e_ms;
    return e;
  endfunction

  function automatic exp_t mk_ill();
    exp_t e;
    e = '0;
    e.illegal = 1'b1;
    e.loose   = 1'b1;
    return e;
  endfunction

  function automatic exp_t observe();
    exp_t o;
    o = '0;
    o.pc = out_pc; o.rs1 = rs1; o.rs2 = rs2; o.rd = rd; o.imm = imm;
    o.alufunc = alufunc; o.alu_bit = alu_bit; o.funcsel = funcsel; o.pcsel = pcsel;
    o.wdsel = wdsel; o.asel = asel; o.bsel = bsel; o.werf = werf; o.mem_en = mem_en;
    o.mem_rw = mem_rw; o.mem_size = mem_size; o.illegal = illegal;
    return o;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  // Monitor: one scoreboard comparison per popped head entry.
  always @(negedge clk) begin
    exp_t o, e;
    logic ok;
    if (rst_n && out_valid && out_ready) begin
      o = observe();
      n_checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_output: got pc=%h entry=%h, expected no output", out_pc, o);
      end else begin
        e = exp_q.pop_front();
        if (e.loose)
          ok = (o.pc === e.pc) && (o.rd === 5'd0) && (o.werf === 1'b0) &&
               (o.mem_en === 1'b0) && (o.pcsel === 2'd0) && (o.illegal === 1'b1);
        else
          ok = (o === e);
        if (!ok) begin
          errors++;
          $display("FAIL decode_pc_%h: got %h, expected %h", e.pc, o, e);
        end
      end
    end
  end

  task automatic send(input logic [31:0] instr, input logic [31:0] pc, input exp_t e_in);
    exp_t e;
    int   waited;
    e = e_in;
    e.pc = pc;
    waited = 0;
    in_valid = 1'b1;
    in_instr = instr;
    in_pc    = pc;
    while (!in_ready && waited < 50) begin
      @(posedge clk); #1;
      waited++;
    end
    if (!in_ready) begin
      n_checks++;
      errors++;
      $display("FAIL accept_timeout pc=%h: got in_ready=0, expected accept within 50 cycles", pc);
    end else begin
      exp_q.push_back(e);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
  endtask

  task automatic drain(input string name);
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 100) begin
      @(posedge clk); #1;
      t++;
    end
    chk(name, exp_q.size(), 0);
  endtask

  exp_t e_addi, e_lui;

  initial begin
    #300000;
    $display("FAIL global_timeout: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_instr = '0; in_pc = '0; out_ready = 1'b1;
    e_addi = mk(5, 1, 0, 32'hFFFFFFFF, 0, 0, 0, 0, 1, 0, 1, 1, 0, 0, 0);
    e_lui  = mk(7, 0, 0, 32'h12345000, 0, 0, 0, 0, 3, 0, 0, 1, 0, 0, 0);
    repeat (2) @(posedge clk); #1;
    chk("reset_out_valid", out_valid, 0);
    chk("reset_in_ready", in_ready, 1);
    n_checks++;
    if (observe() !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got %h, expected all zero", observe());
    end
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Streaming decode of the directed set with out_ready held high.
    send(32'hFFF08293, 32'h1000, e_addi);
    chk("first_latency_out_valid", out_valid, 1);
    send(32'hFE208EE3, 32'h1004, mk(0, 1, 2, 32'hFFFFFFFC, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0));
    send(32'h008000EF, 32'h1008, mk(1, 0, 0, 32'h00000008, 0, 0, 0, 2, 0, 0, 0, 1, 0, 0, 0));
    send(32'h41F1D193, 32'h100C, mk(3, 3, 0, 32'h0000001F, 5, 1, 0, 0, 1, 0, 1, 1, 0, 0, 0));
    send(32'h00000000, 32'h1010, mk_ill());
    send(32'h00002063, 32'h1014, mk_ill());
    send(32'h123453B7, 32'h1018, e_lui);
    send(32'h00812303, 32'h101C, mk(6, 2, 0, 32'h00000008, 0, 0, 0, 0, 2, 0, 1, 1, 1, 1, 2));
    send(32'hFE512E23, 32'h1020, mk(0, 2, 5, 32'hFFFFFFFC, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 2));
    send(32'h402081B3, 32'h1024, mk(3, 1, 2, 32'h00000000, 0, 1, 0, 0, 1, 0, 0, 1, 0, 0, 0));
    send(32'h00001217, 32'h1028, mk(4, 0, 0, 32'h00001000, 0, 0, 0, 0, 1, 1, 1, 1, 0, 0, 0));
    send(32'h00008067, 32'h102C, mk(0, 1, 0, 32'h00000000, 0, 0, 0, 3, 0, 0, 0, 1, 0, 0, 0));
    send(32'h022081B3, 32'h1030, mk_ill());
    send(32'h0FF0000F, 32'h1034, mk(0, 0, 0, 32'h00000000, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    send(32'h00000073, 32'h1038, mk_ill());
    drain("stream_drain");

    // Back-pressure: two entries fill the buffer, a third waits for release.
    out_ready = 1'b0;
    send(32'hFFF08293, 32'h2000, e_addi);
    send(32'h123453B7, 32'h2004, e_lui);
    chk("full_in_ready", in_ready, 0);
    chk("full_out_valid", out_valid, 1);
    chk("full_head_pc", out_pc, 32'h2000);
    fork
      send(32'hFFF08293, 32'h2008, e_addi);
      begin
        repeat (3) @(posedge clk);
        #1;
        chk("stalled_in_ready", in_ready, 0);
        chk("stalled_head_stable", out_pc, 32'h2000);
        out_ready = 1'b1;
      end
    join
    drain("backpressure_drain");

    // Flush with a full buffer and a new instruction presented in the same cycle.
    out_ready = 1'b0;
    send(32'hFFF08293, 32'h3000, e_addi);
    send(32'h123453B7, 32'h3004, e_lui);
    in_valid = 1'b1; in_instr = 32'h123453B7; in_pc = 32'h3008; flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    chk("flush_out_valid", out_valid, 0);
    chk("flush_in_ready", in_ready, 1);
    exp_q.delete();
    out_ready = 1'b1;
    repeat (4) @(posedge clk); #1;
    chk("flush_no_ghost", out_valid, 0);
    send(32'hFFF08293, 32'h300C, e_addi);
    drain("post_flush_drain");

    // Asynchronous reset while holding two entries.
    out_ready = 1'b0;
    send(32'hFFF08293, 32'h4000, e_addi);
    send(32'h123453B7, 32'h4004, e_lui);
    #2;
    rst_n = 1'b0;
    #1;
    chk("areset_out_valid", out_valid, 0);
    chk("areset_in_ready", in_ready, 1);
    n_checks++;
    if (observe() !== '0) begin
      errors++;
      $display("FAIL areset_outputs: got %h, expected all zero", observe());
    end
    exp_q.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    send(32'h123453B7, 32'h5000, e_lui);
    drain("post_reset_drain");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, errors);
    $finish;
  end

endmodule
